tile_z_flush: RTL and testbench

Drains the per-tile 1024-entry depth buffer into VRAM once the rasterizer has finished a tile. Reads the tile RAM through its read port and streams the words out as fixed-length Avalon-style burst writes to a caller-supplied base address. It sits between the tile depth buffer (read side) and the VRAM arbiter (write master side), and is started by the tile sequencer after the last triangle of a tile.

---
 rtl/pvr_pkg.sv | 16 +
 rtl/tile_flush_buf.sv | 28 ++
 rtl/tile_z_flush.sv | 137 +++++++++++++
 tb/tb_tile_z_flush.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pvr_pkg.sv
// Shared constants and types for the tile pipeline (tile size, burst length, flush FSM).
package pvr_pkg;

   localparam int unsigned PVR_TILE_WORDS  = 1024;
   localparam int unsigned PVR_TILE_ADDR_W = $clog2(PVR_TILE_WORDS);
   localparam int unsigned PVR_BURST_LEN   = 8;
   localparam int unsigned PVR_MEM_ADDR_W  = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } flush_state_t;

endpackage

// File: rtl/tile_flush_buf.sv
// Burst staging buffer: one synchronous write port (tile RAM capture),
// one combinational read port (current write beat).
module tile_flush_buf
   import pvr_pkg::*;
#(
   parameter int unsigned DEPTH  = PVR_BURST_LEN,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned DATA_W = 32
) (
   input  logic              clock,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] regs [DEPTH];

   always_ff @(posedge clock) begin
      if (we) regs[waddr] <= wdata;
   end

   always_comb begin
      rdata = regs[raddr];
   end

endmodule

// File: rtl/tile_z_flush.sv
// Streams the tile depth buffer out to VRAM as fixed-length burst writes:
// each burst is first read into a local buffer (FILL), then written out (SEND).
module tile_z_flush
   import pvr_pkg::*;
#(
   parameter int unsigned TILE_WORDS = PVR_TILE_WORDS,
   parameter int unsigned ADDR_W     = $clog2(TILE_WORDS),
   parameter int unsigned BURST_LEN  = PVR_BURST_LEN,
   parameter int unsigned MEM_ADDR_W = PVR_MEM_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [MEM_ADDR_W-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [31:0]           rd_data,
   output logic                  mem_write,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [3:0]            mem_burstcount,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_waitrequest
);

   localparam int unsigned BL_W = $clog2(BURST_LEN);
   localparam int unsigned BI_W = ADDR_W - BL_W;
   localparam int unsigned BLM1 = BURST_LEN - 1;
   localparam logic [BL_W:0]   FILL_LAST = BURST_LEN[BL_W:0];
   localparam logic [BL_W-1:0] BEAT_LAST = BLM1[BL_W-1:0];

   flush_state_t state, state_nx;

   logic [MEM_ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0]     word_ptr;
   logic [BI_W-1:0]       burst_idx;
   logic [BL_W:0]         fill_cnt;
   logic [BL_W-1:0]       beat;
   logic                  rd_en_q;
   logic [BL_W-1:0]       cap_idx_q;
   logic [31:0]           buf_rdata;
   logic                  accept;

   // Read data arrives a cycle after the strobe, so capture uses the delayed strobe/index.
   tile_flush_buf #(
      .DEPTH  (BURST_LEN),
      .IDX_W  (BL_W),
      .DATA_W (32)
   ) u_buf (
      .clock (clock),
      .we    (rd_en_q),
      .waddr (cap_idx_q),
      .wdata (rd_data),
      .raddr (beat),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         base_q    <= '0;
         word_ptr  <= '0;
         burst_idx <= '0;
         fill_cnt  <= '0;
         beat      <= '0;
         rd_en_q   <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         state     <= state_nx;
         rd_en_q   <= rd_en;
         cap_idx_q <= fill_cnt[BL_W-1:0];
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_addr;
                  word_ptr  <= '0;
                  burst_idx <= '0;
                  fill_cnt  <= '0;
                  beat      <= '0;
               end
            end
            FILL: begin
               if (rd_en) word_ptr <= word_ptr + ADDR_W'(1);
               fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + (BL_W+1)'(1);
            end
            SEND: begin
               if (accept) begin
                  beat <= beat + BL_W'(1);
                  if (beat == BEAT_LAST && word_ptr != '0) burst_idx <= burst_idx + BI_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx       = state;
      busy           = 1'b0;
      done           = 1'b0;
      rd_en          = 1'b0;
      rd_addr        = '0;
      mem_write      = 1'b0;
      mem_addr       = '0;
      mem_burstcount = '0;
      mem_wdata      = '0;
      accept         = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = FILL;
         end
         FILL: begin
            busy    = 1'b1;
            rd_en   = (fill_cnt != FILL_LAST);
            rd_addr = word_ptr;
            if (fill_cnt == FILL_LAST) state_nx = SEND;
         end
         SEND: begin
            busy           = 1'b1;
            mem_write      = 1'b1;
            mem_addr       = base_q + MEM_ADDR_W'({burst_idx, {BL_W{1'b0}}});
            mem_burstcount = BURST_LEN[3:0];
            mem_wdata      = buf_rdata;
            accept         = !mem_waitrequest;
            // word_ptr has wrapped to zero once the whole tile has been read
            if (accept && beat == BEAT_LAST) state_nx = (word_ptr == '0) ? DONE : FILL;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tile_z_flush.sv
// Self-checking bench for tile_z_flush: tile RAM model, beat scoreboard, stall and timing checks.
module tb_tile_z_flush;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] base_addr;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;
   logic        mem_write;
   logic [23:0] mem_addr;
   logic [3:0]  mem_burstcount;
   logic [31:0] mem_wdata;
   logic        mem_waitrequest;

   always #5 clock = ~clock;

   tile_z_flush #(
      .TILE_WORDS (1024),
      .ADDR_W     (10),
      .BURST_LEN  (8),
      .MEM_ADDR_W (24)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .busy            (busy),
      .done            (done),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .mem_write       (mem_write),
      .mem_addr        (mem_addr),
      .mem_burstcount  (mem_burstcount),
      .mem_wdata       (mem_wdata),
      .mem_waitrequest (mem_waitrequest)
   );

   // tile depth RAM, one cycle read latency
   logic [31:0] ram [1024];
   always @(posedge clock) begin
      if (rd_en) rd_data <= ram[rd_addr];
   end

   int total = 0;
   int bad   = 0;
   int cyc;
   int done_cnt, done_cyc, first_rd, first_wr;
   int excl_err, stall_err, bc_err;
   logic busy_c1, done_busy;
   bit prev_stall;
   logic [23:0] p_addr;
   logic [31:0] p_data;
   int rd_hits [1024];
   logic [23:0] obs_addr [$];
   logic [31:0] obs_data [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      done_cnt = 0; done_cyc = -1; first_rd = -1; first_wr = -1;
      excl_err = 0; stall_err = 0; bc_err = 0;
      busy_c1 = 1'b0; done_busy = 1'bx; prev_stall = 1'b0;
      for (int i = 0; i < 1024; i++) rd_hits[i] = 0;
      obs_addr.delete();
      obs_data.delete();
   endtask

   task automatic sample();
      if (rd_en && mem_write) excl_err++;
      if (rd_en) begin
         rd_hits[rd_addr]++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (mem_write && first_wr < 0) first_wr = cyc;
      if (mem_write && mem_burstcount != 4'd8) bc_err++;
      if (prev_stall && !(mem_write && mem_addr === p_addr && mem_wdata === p_data)) stall_err++;
      prev_stall = mem_write && mem_waitrequest;
      p_addr = mem_addr;
      p_data = mem_wdata;
      if (mem_write && !mem_waitrequest) begin
         obs_addr.push_back(mem_addr);
         obs_data.push_back(mem_wdata);
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = busy;
      end
      if (cyc == 1) busy_c1 = busy;
   endtask

   task automatic run_cycle(input bit st, input bit wr, input bit rst);
      reset = rst;
      start = st;
      mem_waitrequest = wr;
      @(negedge clock);
      sample();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_flush(input logic [23:0] base, input int unsigned wr_pct, input bit inject);
      bit st;
      clear_stats();
      base_addr = base;
      cyc = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      base_addr = ~base;
      while (done_cnt == 0 && cyc < 6000) begin
         st = inject && (cyc == 5 || cyc == 500 || cyc == 2176 || cyc == 2177);
         run_cycle(st, $urandom_range(99) < wr_pct, 1'b0);
      end
      if (inject) run_cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic check_flush(input logic [23:0] base, input bit timing);
      int cov_err;
      logic [23:0] ea;
      cov_err = 0;
      chk("done_count", done_cnt, 1);
      if (timing) chk("done_cycle", done_cyc, 2177);
      chk("busy_at_done", {31'b0, done_busy}, 32'd0);
      chk("busy_cycle1", {31'b0, busy_c1}, 32'd1);
      chk("first_rd_cycle", first_rd, 1);
      chk("first_wr_cycle", first_wr, 10);
      chk("rd_wr_exclusive", excl_err, 0);
      chk("stall_hold", stall_err, 0);
      chk("burstcount", bc_err, 0);
      for (int i = 0; i < 1024; i++) if (rd_hits[i] != 1) cov_err++;
      chk("rd_addr_coverage", cov_err, 0);
      chk("beat_count", obs_addr.size(), 1024);
      for (int i = 0; i < obs_addr.size() && i < 1024; i++) begin
         ea = base + 24'(8 * (i / 8));
         chk($sformatf("beat%0d_addr", i), {8'h0, obs_addr[i]}, {8'h0, ea});
         chk($sformatf("beat%0d_data", i), obs_data[i], ram[i]);
         if (bad > 40) break;
      end
   endtask

   task automatic check_rst_outputs(input string tag);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, done}, 32'd0);
      chk({tag, "_rd_en"}, {31'b0, rd_en}, 32'd0);
      chk({tag, "_rd_addr"}, {22'b0, rd_addr}, 32'd0);
      chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
      chk({tag, "_mem_addr"}, {8'b0, mem_addr}, 32'd0);
      chk({tag, "_burstcount"}, {28'b0, mem_burstcount}, 32'd0);
      chk({tag, "_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      logic [23:0] b;
      logic [23:0] a8;
      reset = 1'b1; start = 1'b0; base_addr = '0; mem_waitrequest = 1'b0;
      for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
      repeat (3) @(posedge clock);
      #4;
      check_rst_outputs("por");
      @(posedge clock);
      #1;
      reset = 1'b0;

      do_flush(24'h100000, 0, 1'b0);
      check_flush(24'h100000, 1'b1);

      do_flush(24'h100000, 30, 1'b0);
      check_flush(24'h100000, 1'b0);

      // ignored starts at 5, 500, 2176, 2177; the one right after done must launch a full flush
      do_flush(24'hFFFFFC, 0, 1'b1);
      check_flush(24'hFFFFFC, 1'b1);
      a8 = (obs_addr.size() > 8) ? obs_addr[8] : 24'hx;
      chk("wrap_burst0", {8'h0, (obs_addr.size() > 0) ? obs_addr[0] : 24'hx}, 32'h00FFFFFC);
      chk("wrap_burst1", {8'h0, a8}, 32'h00000004);
      while (done_cnt < 2 && cyc < 6000) run_cycle(1'b0, 1'b0, 1'b0);
      chk("post_done_start_flush", done_cnt, 2);
      chk("post_done_start_cycle", done_cyc, 2178 + 2177);

      for (int i = 0; i < 1024; i++) ram[i] = $urandom;
      clear_stats();
      b = 24'($urandom);
      base_addr = b;
      cyc = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      while (obs_addr.size() < 323 && cyc < 6000) run_cycle(1'b0, $urandom_range(99) < 30, 1'b0);
      chk("reached_burst40", {31'b0, obs_addr.size() >= 323}, 32'd1);
      chk("abort_stall_hold", stall_err, 0);
      chk("abort_rd_wr_exclusive", excl_err, 0);
      run_cycle(1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      #4;
      check_rst_outputs("abort");
      @(posedge clock);
      #1;

      b = 24'($urandom);
      do_flush(b, 30, 1'b0);
      check_flush(b, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
